// File: rtl/cdc_hk_wr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : cdc_hk_wr_arb
//  Description : Write-domain round-robin arbiter/sequencer that shares one
//                CDC toggle-handshake channel among NUM_REQ requesters.
//                Grants one requester, presents a single token to the
//                channel, waits for the round trip and pulses done to the
//                winner. Provides a sticky timeout flag and a transfer count.
//  Revision    : 1.0 - initial release
// ============================================================================
module cdc_hk_wr_arb #(
    parameter int NUM_REQ  = 4,
    parameter int ID_W     = 2,
    parameter int TO_W     = 8,
    parameter int TO_LIMIT = 200
) (
    input  logic                wclk,
    input  logic                wr_rst_n,
    input  logic                arb_en,
    input  logic [NUM_REQ-1:0]  req,
    output logic [NUM_REQ-1:0]  gnt,
    output logic [ID_W-1:0]     gnt_id,
    output logic [NUM_REQ-1:0]  done,
    output logic                hk_wr_vld,
    input  logic                hk_wr_rdy,
    output logic                busy,
    output logic                timeout_err,
    input  logic                clr_err,
    output logic [15:0]         xfer_cnt
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_SEND     = 2'd1,
        S_WAIT_ACK = 2'd2
    } state_t;

    localparam logic [ID_W:0]   C_NREQ_EXT = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0] C_LAST_ID  = ID_W'(NUM_REQ - 1);
    localparam logic [TO_W-1:0] C_TO_LIMIT = TO_W'(TO_LIMIT);

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [ID_W-1:0]      gnt_id_q, gnt_id_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic [ID_W-1:0]      ptr_q, ptr_d;
    logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
    logic                 timeout_err_q, timeout_err_d;
    logic [15:0]          xfer_cnt_q, xfer_cnt_d;

    logic [ID_W:0]        cand;
    logic                 found;
    logic [ID_W-1:0]      sel_id;
    logic [TO_W-1:0]      to_cnt_inc;
    logic                 to_set;

    // Round-robin search: first requesting index at or above the pointer, wrapping.
    always_comb begin
        found  = 1'b0;
        sel_id = '0;
        cand   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr_q} + (ID_W+1)'(i);
            if (cand >= C_NREQ_EXT) begin
                cand = cand - C_NREQ_EXT;
            end
            if (!found && req[cand[ID_W-1:0]]) begin
                found  = 1'b1;
                sel_id = cand[ID_W-1:0];
            end
        end
    end

    // Round-trip timeout: the flag fires on the cycle the counter reaches the limit.
    always_comb begin
        to_cnt_inc = to_cnt_q + 1'b1;
        to_set     = (state_q == S_WAIT_ACK) && (to_cnt_q != '1) &&
                     (to_cnt_inc == C_TO_LIMIT);
    end

    // Next-state and datapath updates for the grant/send/wait sequence.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_id_d    = gnt_id_q;
        done_d      = '0;
        ptr_d       = ptr_q;
        to_cnt_d    = to_cnt_q;
        xfer_cnt_d  = xfer_cnt_q;

        case (state_q)
            S_IDLE: begin
                // req is only looked at here; later deassertion cannot cancel a transfer.
                if (arb_en && found) begin
                    gnt_d          = '0;
                    gnt_d[sel_id]  = 1'b1;
                    gnt_id_d       = sel_id;
                    state_d        = S_SEND;
                end
            end
            S_SEND: begin
                // Token stays offered while the previous round trip is still pending.
                if (hk_wr_rdy) begin
                    state_d = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                if (hk_wr_rdy) begin
                    state_d    = S_IDLE;
                    done_d     = gnt_q;
                    gnt_d      = '0;
                    ptr_d      = (gnt_id_q == C_LAST_ID) ? '0 : gnt_id_q + 1'b1;
                    xfer_cnt_d = xfer_cnt_q + 16'd1;
                    to_cnt_d   = '0;
                end else if (to_cnt_q != '1) begin
                    to_cnt_d = to_cnt_inc;
                end
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
            end
        endcase

        // Set has priority over a simultaneous clear.
        if (to_set) begin
            timeout_err_d = 1'b1;
        end else if (clr_err) begin
            timeout_err_d = 1'b0;
        end else begin
            timeout_err_d = timeout_err_q;
        end
    end

    // State and datapath registers; reset abandons any in-flight transfer.
    always_ff @(posedge wclk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            state_q       <= S_IDLE;
            gnt_q         <= '0;
            gnt_id_q      <= '0;
            done_q        <= '0;
            ptr_q         <= '0;
            to_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
            xfer_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            gnt_id_q      <= gnt_id_d;
            done_q        <= done_d;
            ptr_q         <= ptr_d;
            to_cnt_q      <= to_cnt_d;
            timeout_err_q <= timeout_err_d;
            xfer_cnt_q    <= xfer_cnt_d;
        end
    end

    assign gnt         = gnt_q;
    assign gnt_id      = gnt_id_q;
    assign done        = done_q;
    assign hk_wr_vld   = (state_q == S_SEND);
    assign busy        = (state_q != S_IDLE);
    assign timeout_err = timeout_err_q;
    assign xfer_cnt    = xfer_cnt_q;

endmodule
`default_nettype wire
